keccak_byte_packer: RTL and testbench

Upstream feeder for the keccak core. Accepts a byte stream with valid/ready/last and packs it into the core's 32-bit word interface: in, in_ready, is_last, byte_num, with buffer_full backpressure. The first byte goes in bits [31:24]. The block generates the core's end-of-message word rules, including the extra all-zero last word when the message length is a multiple of 4. One message is handled per reset, matching the core, which is also reset between messages.

---
 rtl/keccak_byte_packer.sv | 146 ++++++++++++++
 tb/tb_keccak_byte_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready byte stream into the keccak core's 32-bit word interface.
// It also generates the core's end-of-message words (is_last/byte_num and the trailing zero word).
module keccak_byte_packer #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [31:0]      k_in,
  output logic             k_in_ready,
  output logic             k_is_last,
  output logic [1:0]       k_byte_num,
  input  logic             buffer_full,
  output logic             msg_done,
  output logic [LEN_W-1:0] msg_len,
  output logic             protocol_err
);

  typedef enum logic [1:0] {FILL, SEND, ZERO, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               zero_q, zero_d;
  logic [1:0]         bnum_q, bnum_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               perr_q, perr_d;

  assign msg_len      = len_q;
  assign protocol_err = perr_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    zero_d     = zero_q;
    bnum_d     = bnum_q;
    len_d      = len_q;
    perr_d     = perr_q;
    s_ready    = 1'b0;
    k_in       = 32'h0000_0000;
    k_in_ready = 1'b0;
    k_is_last  = 1'b0;
    k_byte_num = 2'd0;
    msg_done   = 1'b0;

    case (state_q)
      FILL: begin
        s_ready = ~reset;
        if (s_valid && !reset) begin
          case (cnt_q)
            2'd0:    word_d[31:24] = s_data;
            2'd1:    word_d[23:16] = s_data;
            2'd2:    word_d[15:8]  = s_data;
            2'd3:    word_d[7:0]   = s_data;
            default: word_d        = word_q;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (len_q != {LEN_W{1'b1}}) begin
            len_d = len_q + LEN_W'(1);
          end else begin
            len_d = len_q;
          end
          // A full word ending the message is followed by a separate all-zero last word.
          if (s_last || (cnt_q == 2'd3)) begin
            state_d = SEND;
            last_d  = s_last && (cnt_q != 2'd3);
            zero_d  = s_last && (cnt_q == 2'd3);
            bnum_d  = cnt_q + 2'd1;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      SEND: begin
        k_in       = word_q;
        k_in_ready = ~buffer_full & ~reset;
        k_is_last  = last_q & k_in_ready;
        k_byte_num = last_q ? bnum_q : 2'd0;
        if (k_in_ready) begin
          cnt_d  = 2'd0;
          word_d = 32'h0000_0000;
          if (last_q) begin
            state_d = DONE;
          end else if (zero_q) begin
            state_d = ZERO;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = SEND;
        end
      end
      ZERO: begin
        k_in_ready = ~buffer_full & ~reset;
        k_is_last  = k_in_ready;
        if (k_in_ready) begin
          state_d = DONE;
        end else begin
          state_d = ZERO;
        end
      end
      DONE: begin
        msg_done = 1'b1;
        if (s_valid) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      word_q  <= 32'h0000_0000;
      cnt_q   <= 2'd0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      bnum_q  <= 2'd0;
      len_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
      bnum_q  <= bnum_d;
      len_q   <= len_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Bench for keccak_byte_packer: directed messages plus random messages with random backpressure.
// Every transfer is checked against a word list computed directly from the message bytes.
module tb_keccak_byte_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] k_in;
  logic        k_in_ready;
  logic        k_is_last;
  logic [1:0]  k_byte_num;
  logic        buffer_full = 1'b0;
  logic        msg_done;
  logic [31:0] msg_len;
  logic        protocol_err;

  int n_checks = 0;
  int n_err = 0;
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];
  logic [7:0]  msg_q[$];
  bit          bf_force = 1'b0;
  bit          rand_en = 1'b0;
  bit          viol_seen = 1'b0;
  bit          clr_mon = 1'b0;

  keccak_byte_packer #(.LEN_W(32)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last),
    .k_byte_num(k_byte_num), .buffer_full(buffer_full), .msg_done(msg_done),
    .msg_len(msg_len), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Core backpressure: forced by directed steps or randomized.
  always @(posedge clk) begin
    #2;
    buffer_full = bf_force || (rand_en && ($urandom_range(0, 2) == 0));
  end

  // Records every word transfer; sampled mid-cycle, ahead of the edge that transfers it.
  always @(negedge clk) begin
    if (clr_mon) begin
      got_q.delete();
      viol_seen = 1'b0;
    end else if (!reset) begin
      if (k_in_ready) got_q.push_back({k_in, k_is_last, k_byte_num});
      if (k_is_last && !k_in_ready) viol_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Expected transfers: bytes big-endian into words, tail marked last, or a zero last word if aligned.
  task automatic build_exp();
    int n;
    logic [31:0] w;
    n = msg_q.size();
    exp_q.delete();
    for (int wi = 0; wi < (n + 3) / 4; wi++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * wi + j < n) w[31 - 8 * j -: 8] = msg_q[4 * wi + j];
      if ((n % 4 != 0) && (wi == (n + 3) / 4 - 1))
        exp_q.push_back({w, 1'b1, 2'(n % 4)});
      else
        exp_q.push_back({w, 1'b0, 2'd0});
    end
    if (n % 4 == 0) exp_q.push_back({32'h0, 1'b1, 2'd0});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    chk("rst_cycle_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_k_in", 64'(k_in), 64'd0);
    chk("rst_k_in_ready", 64'(k_in_ready), 64'd0);
    chk("rst_k_is_last", 64'(k_is_last), 64'd0);
    chk("rst_k_byte_num", 64'(k_byte_num), 64'd0);
    chk("rst_msg_done", 64'(msg_done), 64'd0);
    chk("rst_msg_len", 64'(msg_len), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);
    clr_mon = 1'b1;
    @(posedge clk); #1;
    clr_mon = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit last, input bit gaps);
    bit rdy;
    int t;
    for (int i = lo; i <= hi; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_data = msg_q[i];
      s_valid = 1'b1;
      s_last = last && (i == hi);
      t = 0;
      do begin
        @(negedge clk);
        rdy = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!rdy && t < 300);
      if (!rdy) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!msg_done && t < 300);
    chk({tag, "_done"}, 64'(msg_done), 64'd1);
    chk({tag, "_len"}, 64'(msg_len), 64'(msg_q.size()));
    chk({tag, "_last_wo_ready"}, 64'(viol_seen), 64'd0);
  endtask

  task automatic check_msg(input string tag);
    int nlast = 0;
    build_exp();
    chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    for (int i = 0; i < got_q.size(); i++) if (got_q[i][2]) nlast++;
    chk({tag, "_nlast"}, 64'(nlast), 64'd1);
  endtask

  initial begin
    logic [34:0] e;
    logic [31:0] held;
    int nlast;

    do_reset();

    load_str("The quick brown fox jumps over the lazy dog");
    send_range(0, 42, 1'b1, 1'b0);
    wait_done("fox");
    check_msg("fox");
    chk("fox_count", 64'(got_q.size()), 64'd11);
    e = got_q[0];
    chk("fox_first", 64'(e[34:3]), 64'h54686520);
    e = got_q[got_q.size() - 1];
    chk("fox_last", 64'(e), 64'({32'h646F6700, 1'b1, 2'd3}));

    do_reset();
    load_str("Hello, world");
    send_range(0, 11, 1'b1, 1'b0);
    wait_done("hw12");
    check_msg("hw12");
    e = got_q[2];
    chk("hw12_w2", 64'(e), 64'({32'h6F726C64, 1'b0, 2'd0}));
    e = got_q[3];
    chk("hw12_zero", 64'(e), 64'({32'h0, 1'b1, 2'd0}));

    do_reset();
    load_str("Hello, world!");
    send_range(0, 12, 1'b1, 1'b0);
    wait_done("hw13");
    check_msg("hw13");
    chk("hw13_count", 64'(got_q.size()), 64'd4);
    e = got_q[3];
    chk("hw13_last", 64'(e), 64'({32'h21000000, 1'b1, 2'd1}));

    // Stall the first word for 5 cycles.
    do_reset();
    load_rand(8);
    build_exp();
    e = exp_q[0];
    held = e[34:3];
    bf_force = 1'b1;
    send_range(0, 3, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), 64'(k_in_ready), 64'd0);
      chk($sformatf("stall%0d_k_in", c), 64'(k_in), 64'(held));
      chk($sformatf("stall%0d_s_ready", c), 64'(s_ready), 64'd0);
      @(posedge clk); #1;
    end
    bf_force = 1'b0;
    send_range(4, 7, 1'b1, 1'b0);
    wait_done("stall");
    check_msg("stall");

    // Reset in the middle of a message discards it.
    do_reset();
    load_str("password123");
    send_range(0, 5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    nlast = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i][2]) nlast++;
    chk("midrst_no_last", 64'(nlast), 64'd0);
    do_reset();
    send_range(0, 10, 1'b1, 1'b0);
    wait_done("pw");
    check_msg("pw");
    e = got_q[2];
    chk("pw_last", 64'(e), 64'({32'h31323300, 1'b1, 2'd3}));

    // Bytes offered after completion.
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    @(negedge clk);
    chk("perr_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("perr_set", 64'(protocol_err), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("perr_sticky", 64'(protocol_err), 64'd1);
    chk("perr_done", 64'(msg_done), 64'd1);

    // Random messages with random gaps and random backpressure.
    for (int m = 0; m < 8; m++) begin
      int len;
      len = (m == 0) ? 1 : (m == 1) ? 4 : $urandom_range(1, 24);
      rand_en = 1'b0;
      do_reset();
      rand_en = 1'b1;
      load_rand(len);
      send_range(0, len - 1, 1'b1, 1'b1);
      wait_done($sformatf("rnd%0d", m));
      check_msg($sformatf("rnd%0d", m));
    end
    rand_en = 1'b0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
